// File: rtl/game_pkg.sv
// game_pkg: shared game-state encoding, per-level board sizes and mine counts.
package game_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        PLAY  = 2'd1,
        WON   = 2'd2,
        LOST  = 2'd3
    } game_state_t;

    localparam logic [4:0] EASY_DIM     = 5'd8;
    localparam logic [4:0] MEDIUM_DIM   = 5'd10;
    localparam logic [4:0] HARD_DIM     = 5'd16;
    localparam logic [6:0] EASY_MINES   = 7'd10;
    localparam logic [6:0] MEDIUM_MINES = 7'd15;
    localparam logic [6:0] HARD_MINES   = 7'd40;

    // Level 0 falls through to easy.
    function automatic logic [4:0] board_dim(input logic [1:0] level);
        return level == 2'd2 ? MEDIUM_DIM : level == 2'd3 ? HARD_DIM : EASY_DIM;
    endfunction

    function automatic logic [6:0] mine_count(input logic [1:0] level);
        return level == 2'd2 ? MEDIUM_MINES : level == 2'd3 ? HARD_MINES : EASY_MINES;
    endfunction

    function automatic logic [8:0] safe_cells(input logic [1:0] level);
        logic [8:0] d;
        d = {4'd0, board_dim(level)};
        return 9'(d * d) - {2'd0, mine_count(level)};
    endfunction

endpackage

// File: rtl/board_state_tracker_if.sv
// board_state_tracker_if: registered mine-check results feeding the state tracker.
interface board_state_tracker_if;
    logic       check_valid;
    logic [4:0] button_ind_x_in;
    logic [4:0] button_ind_y_in;
    logic       explode;
    logic       mark_flag;

    modport master (output check_valid, button_ind_x_in, button_ind_y_in, explode, mark_flag);
    modport slave  (input  check_valid, button_ind_x_in, button_ind_y_in, explode, mark_flag);
endinterface

// File: rtl/game_timer.sv
// game_timer: CLK_HZ prescaler driving a seconds counter that saturates at 999.
module game_timer #(
    parameter int CLK_HZ = 65_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       run,
    output logic [9:0] elapsed_s
);
    localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;

    logic [PW-1:0] pre;
    logic          tick;

    assign tick = pre == PW'(CLK_HZ - 1);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            pre       <= '0;
            elapsed_s <= '0;
        end else if (run) begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick && elapsed_s != 10'd999)
                elapsed_s <= elapsed_s + 10'd1;
        end
    end
endmodule

// File: rtl/board_state_tracker.sv
// board_state_tracker: revealed/flagged bitmaps, flag budget and game FSM.
// Define GAME_TIMER_EN to add the elapsed_s play-time output.
module board_state_tracker
    import game_pkg::*;
#(
    parameter int MAX_DIM = 16,
    parameter int CLK_HZ  = 65_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [1:0]                        level,
    board_state_tracker_if.slave              chk,
    output logic [MAX_DIM-1:0][MAX_DIM-1:0]   revealed,
    output logic [MAX_DIM-1:0][MAX_DIM-1:0]   flagged,
    output logic [6:0]                        flags_left,
    output logic [1:0]                        game_state,
    output logic                              busy
`ifdef GAME_TIMER_EN
    ,
    output logic [9:0]                        elapsed_s
`endif
);
    localparam int IW = $clog2(MAX_DIM);

    localparam logic [1:0] S_CLEAR = CLEAR;
    localparam logic [1:0] S_PLAY  = PLAY;
    localparam logic [1:0] S_WON   = WON;
    localparam logic [1:0] S_LOST  = LOST;

    // The hard level needs a 16x16 bitmap.
    if (MAX_DIM < 16 || CLK_HZ < 1) begin : g_bad_cfg
        $error("board_state_tracker: MAX_DIM must be >= 16 and CLK_HZ >= 1");
    end

    logic [1:0]    state;
    logic [1:0]    level_q;
    logic [IW-1:0] row_cnt;
    logic [8:0]    revealed_cnt;
    logic [8:0]    next_cnt;
    logic [4:0]    dim;
    logic [IW-1:0] cx;
    logic [IW-1:0] cy;
    logic          in_rng;
    logic          cell_rev;
    logic          cell_flag;
    logic          accept;
    logic          do_flag;
    logic          do_reveal;
    logic          last_row;

    assign game_state = state;

    always_comb begin
        dim       = board_dim(level_q);
        cx        = chk.button_ind_x_in[IW-1:0];
        cy        = chk.button_ind_y_in[IW-1:0];
        in_rng    = chk.button_ind_x_in < dim && chk.button_ind_y_in < dim;
        cell_rev  = revealed[cy][cx];
        cell_flag = flagged[cy][cx];
        // start takes priority, so a coincident strobe is dropped.
        accept    = state == S_PLAY && chk.check_valid && !start && in_rng;
        do_flag   = accept && chk.mark_flag && !cell_rev && (cell_flag || flags_left != 7'd0);
        do_reveal = accept && !chk.mark_flag && !cell_rev && !cell_flag;
        next_cnt  = revealed_cnt + 9'd1;
        last_row  = row_cnt == IW'(MAX_DIM - 1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_CLEAR;
            level_q      <= 2'd0;
            row_cnt      <= '0;
            busy         <= 1'b0;
            revealed     <= '0;
            flagged      <= '0;
            flags_left   <= 7'd0;
            revealed_cnt <= 9'd0;
        end else if (start) begin
            state   <= S_CLEAR;
            level_q <= level;
            row_cnt <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            revealed[row_cnt] <= '0;
            flagged[row_cnt]  <= '0;
            row_cnt           <= last_row ? '0 : row_cnt + 1'b1;
            if (last_row) begin
                busy         <= 1'b0;
                state        <= S_PLAY;
                flags_left   <= mine_count(level_q);
                revealed_cnt <= 9'd0;
            end
        end else if (do_flag) begin
            flagged[cy][cx] <= !cell_flag;
            flags_left      <= cell_flag ? flags_left + 7'd1 : flags_left - 7'd1;
        end else if (do_reveal) begin
            revealed[cy][cx] <= 1'b1;
            if (chk.explode) begin
                state <= S_LOST;
            end else begin
                revealed_cnt <= next_cnt;
                if (next_cnt == safe_cells(level_q))
                    state <= S_WON;
            end
        end
    end

`ifdef GAME_TIMER_EN
    game_timer #(.CLK_HZ(CLK_HZ)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (start),
        .run       (state == S_PLAY),
        .elapsed_s (elapsed_s)
    );
`endif
endmodule

// File: tb/tb_board_state_tracker.sv
// tb_board_state_tracker: directed vectors plus hand-written sweep, win, loss and flag-budget sequences.
module tb_board_state_tracker;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        level = 2'd0;
    logic [15:0][15:0] revealed;
    logic [15:0][15:0] flagged;
    logic [6:0]        flags_left;
    logic [1:0]        game_state;
    logic              busy;
`ifdef GAME_TIMER_EN
    logic [9:0]        elapsed_s;
`endif

    int checks = 0;
    int errors = 0;

    board_state_tracker_if chk_if();

    board_state_tracker #(.MAX_DIM(16), .CLK_HZ(65_000_000)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .level      (level),
        .chk        (chk_if.slave),
        .revealed   (revealed),
        .flagged    (flagged),
        .flags_left (flags_left),
        .game_state (game_state),
        .busy       (busy)
`ifdef GAME_TIMER_EN
        ,
        .elapsed_s  (elapsed_s)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic mark;
        logic explode;
        int   x;
        int   y;
        int   flags;
        int   state;
        int   rev;
        int   flg;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic strobe(input int x, input int y, input logic e, input logic m);
        chk_if.check_valid     = 1'b1;
        chk_if.button_ind_x_in = 5'(x);
        chk_if.button_ind_y_in = 5'(y);
        chk_if.explode         = e;
        chk_if.mark_flag       = m;
        @(posedge clk);
        #1;
        chk_if.check_valid = 1'b0;
        chk_if.explode     = 1'b0;
        chk_if.mark_flag   = 1'b0;
    endtask

    task automatic pulse_start(input int lvl);
        start = 1'b1;
        level = 2'(lvl);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_sweep(input int mines);
        int n = 0;
        while (busy && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("sweep_len", n, 16);
        chk("sweep_state", game_state, 1);
        chk("sweep_flags", flags_left, mines);
        chk("sweep_rev_clear", $countones(revealed), 0);
        chk("sweep_flag_clear", $countones(flagged), 0);
    endtask

    initial begin
        int cnt;
        tbl[0]  = '{1'b1, 1'b0, 3, 2,  9, 1, 0, 1};
        tbl[1]  = '{1'b1, 1'b0, 3, 2, 10, 1, 0, 0};
        tbl[2]  = '{1'b1, 1'b0, 5, 5,  9, 1, 0, 1};
        tbl[3]  = '{1'b0, 1'b0, 5, 5,  9, 1, 0, 1};
        tbl[4]  = '{1'b1, 1'b0, 9, 0,  9, 1, 0, 0};
        tbl[5]  = '{1'b1, 1'b0, 5, 5, 10, 1, 0, 0};
        tbl[6]  = '{1'b0, 1'b0, 5, 5, 10, 1, 1, 0};
        tbl[7]  = '{1'b1, 1'b0, 5, 5, 10, 1, 1, 0};
        tbl[8]  = '{1'b0, 1'b0, 5, 5, 10, 1, 1, 0};
        tbl[9]  = '{1'b1, 1'b1, 1, 1,  9, 1, 0, 1};
        tbl[10] = '{1'b1, 1'b1, 1, 1, 10, 1, 0, 0};
        tbl[11] = '{1'b0, 1'b0, 9, 0, 10, 1, 0, 0};

        chk_if.check_valid     = 1'b0;
        chk_if.button_ind_x_in = 5'd0;
        chk_if.button_ind_y_in = 5'd0;
        chk_if.explode         = 1'b0;
        chk_if.mark_flag       = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", game_state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flags", flags_left, 0);
        chk("rst_rev", $countones(revealed), 0);
        chk("rst_flag", $countones(flagged), 0);
        rst = 1'b1;

        pulse_start(1);
        chk("start_busy", busy, 1);
        wait_sweep(10);

        for (int i = 0; i < 12; i++) begin
            strobe(tbl[i].x, tbl[i].y, tbl[i].explode, tbl[i].mark);
            chk($sformatf("vec%0d_flags", i), flags_left, tbl[i].flags);
            chk($sformatf("vec%0d_state", i), game_state, tbl[i].state);
            chk($sformatf("vec%0d_rev", i), revealed[tbl[i].y][tbl[i].x], tbl[i].rev);
            chk($sformatf("vec%0d_flg", i), flagged[tbl[i].y][tbl[i].x], tbl[i].flg);
        end

        // (5,5) is already revealed: 53 more distinct safe reveals reach 54 = 64 - 10.
        cnt = 0;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                if (cnt < 53 && !(x == 5 && y == 5)) begin
                    strobe(x, y, 1'b0, 1'b0);
                    cnt++;
                    chk($sformatf("win_state_%0d", cnt), game_state, cnt == 53 ? 2 : 1);
                    chk("win_rev", revealed[y][x], 1);
                end
        strobe(0, 7, 1'b0, 1'b0);
        chk("won_frozen_rev", revealed[7][0], 0);
        chk("won_state_hold", game_state, 2);
        strobe(1, 7, 1'b0, 1'b1);
        chk("won_frozen_flag", flagged[7][1], 0);
        chk("won_flags_hold", flags_left, 10);

        pulse_start(1);
        wait_sweep(10);
        strobe(0, 0, 1'b1, 1'b0);
        chk("lost_rev", revealed[0][0], 1);
        chk("lost_state", game_state, 3);
        strobe(1, 0, 1'b0, 1'b0);
        chk("lost_frozen_rev", revealed[0][1], 0);
        chk("lost_state_hold", game_state, 3);
        pulse_start(1);
        wait_sweep(10);

        for (int i = 0; i < 10; i++)
            strobe(i % 8, i / 8, 1'b0, 1'b1);
        chk("budget_empty", flags_left, 0);
        chk("budget_count", $countones(flagged), 10);
        strobe(2, 1, 1'b0, 1'b1);
        chk("budget_11th_flag", flagged[1][2], 0);
        chk("budget_11th_left", flags_left, 0);

        // start coincident with a strobe: the strobe must be dropped.
        start                  = 1'b1;
        level                  = 2'd3;
        chk_if.check_valid     = 1'b1;
        chk_if.mark_flag       = 1'b1;
        chk_if.button_ind_x_in = 5'd1;
        chk_if.button_ind_y_in = 5'd0;
        @(posedge clk);
        #1;
        start              = 1'b0;
        chk_if.check_valid = 1'b0;
        chk_if.mark_flag   = 1'b0;
        chk("coinc_busy", busy, 1);
        chk("coinc_state", game_state, 0);
        chk("coinc_flag_kept", flagged[0][1], 1);
        chk("coinc_flags", flags_left, 0);
        wait_sweep(40);

        strobe(15, 15, 1'b0, 1'b0);
        chk("hard_edge_rev", revealed[15][15], 1);
        strobe(16, 0, 1'b0, 1'b0);
        chk("hard_oob", $countones(revealed), 1);

        pulse_start(2);
        repeat (5) @(posedge clk);
        #1;
        chk("restart_busy", busy, 1);
        pulse_start(2);
        wait_sweep(15);
        strobe(10, 0, 1'b0, 1'b0);
        chk("med_oob", $countones(revealed), 0);
        strobe(9, 9, 1'b0, 1'b0);
        chk("med_edge_rev", revealed[9][9], 1);

        pulse_start(0);
        wait_sweep(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/board_state_tracker.md
Name: board_state_tracker

Overview:
- Sits directly downstream of the mine-check stage and consumes its registered coordinates plus the explode/mark_flag results.
- Holds the per-cell revealed and flagged bitmaps for the active board, the flag budget and the revealed-cell count.
- Runs the game-state FSM (clear, play, won, lost).
- Its bitmaps and status feed the board drawing and status display stages.

Parameters:
- MAX_DIM, 16, side of the largest board; sizes the bitmaps.
- CLK_HZ, 65_000_000, clock frequency; used only by the optional timer.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begin a new game at the current level.
- level  in  2  1 = easy 8x8, 2 = medium 10x10, 3 = hard 16x16, 0 = treated as easy.
- check_valid  in  1  one-cycle strobe aligned with the mine-check outputs; marks a real click.
- button_ind_x_in  in  5  column of the checked cell.
- button_ind_y_in  in  5  row of the checked cell.
- explode  in  1  the checked cell is a mine.
- mark_flag  in  1  the click is a flag toggle.
- revealed  out  [MAX_DIM-1:0][MAX_DIM-1:0]  1 = cell opened.
- flagged  out  [MAX_DIM-1:0][MAX_DIM-1:0]  1 = cell carries a flag.
- flags_left  out  7  remaining flag budget.
- game_state  out  2  CLEAR = 0, PLAY = 1, WON = 2, LOST = 3.
- busy  out  1  high while clearing.

Behaviour:
- Reset (rst == 0 at a clk edge): bitmaps all 0, flags_left = 0, revealed_cnt = 0, game_state = CLEAR, busy = 0, row counter = 0.
- Latches level on start into level_q. Board size: 8, 10 or 16. Mines: 10, 15 or 40.
- CLEAR state:
  - Idle at 0 until start.
  - On start, busy = 1 and one bitmap row is zeroed per cycle for MAX_DIM cycles (row counter 0..MAX_DIM-1).
  - On the last row, loads flags_left = mine count and revealed_cnt = 0, then goes to PLAY. busy drops in the same edge.
  - A start that arrives while busy restarts the sweep at row 0.
- PLAY state, acting only when check_valid = 1:
  - Coordinates with x >= size or y >= size: ignored.
  - mark_flag = 1, cell not revealed:
    - flagged = 1: clear it and increment flags_left.
    - flagged = 0 and flags_left > 0: set it and decrement flags_left.
    - flagged = 0 and flags_left == 0: ignored.
  - mark_flag = 1, cell revealed: ignored.
  - mark_flag = 0, cell flagged or already revealed: ignored.
  - mark_flag = 0, explode = 1: set the revealed bit and go to LOST.
  - mark_flag = 0, explode = 0: set the revealed bit and increment revealed_cnt (9 bits).
  - When the next revealed_cnt equals size*size - mines, go to WON in the same edge.
- All updates appear on outputs one cycle after the check_valid edge. There is no backpressure; one strobe is accepted per cycle.
- WON / LOST: all strobes are ignored and bitmaps are frozen. Only start (goes to CLEAR and sweeps) or reset leaves these states.
- start in PLAY abandons the game and begins the sweep. start together with check_valid: start wins and the strobe is dropped.
- mark_flag together with explode: treated as a flag toggle.

Optional Feature:
- GAME_TIMER_EN defined:
  - Adds output elapsed_s [9:0] and a prescaler counting CLK_HZ cycles.
  - elapsed_s increments once per second only in PLAY and saturates at 999.
  - Cleared by reset and by start. Frozen in WON/LOST.
- GAME_TIMER_EN undefined: no port, no counter logic.

Decomposition:
- Package game_pkg holds:
  - game_state_t enum.
  - Constants EASY_DIM/MEDIUM_DIM/HARD_DIM = 8/10/16 and EASY_MINES/MEDIUM_MINES/HARD_MINES = 10/15/40.
  - Functions board_dim(level) and mine_count(level).
- One natural sub-module: game_timer (prescaler plus saturating seconds counter), instantiated only under GAME_TIMER_EN.

Test Plan:
- Reset then start with level = 1 -> busy high for 16 cycles, then game_state = PLAY, flags_left = 10, bitmaps 0.
- In PLAY, check_valid with mark_flag = 1 at (3,2) twice -> flagged[2][3] goes 1 then 0; flags_left goes 10, 9, 10.
- Reveal a flagged cell (5,5) with explode = 0 -> no change. Then x = 9 at level 1 -> ignored. Then reveal (5,5) after unflagging -> revealed[5][5] = 1.
- Level 1, reveal 54 distinct safe cells -> game_state = WON on the cycle after the 54th strobe; later strobes ignored.
- Reveal with explode = 1 at (0,0) -> revealed[0][0] = 1, game_state = LOST. Then start -> sweep, then PLAY with cleared bitmaps.
- Flag 10 cells, then try an 11th -> ignored and flags_left stays 0. start and check_valid in the same cycle -> strobe dropped, sweep begins.
